// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 non-restoring integer divider, one quotient bit per cycle.
// Each iteration's add/subtract goes through a parallel-prefix (p/g carry-lookahead) adder.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   operand handshake (dividend, divisor)
//   out_valid / out_ready result handshake (quotient, remainder, div_by_zero)
//   busy                  high while iterating
//
// Optional: define SEQ_DIVIDER_SIGNED_EN to add the signed_op input (two's complement
// division, quotient truncates toward zero, remainder takes the dividend's sign).
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  // Parallel-prefix adder: gp/pp end up as group generate/propagate of bits [i:0].
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                                             input logic cin);
    logic [WIDTH:0] p, gp, pp, gn, pn, c;
    p  = a ^ b;
    gp = a & b;
    pp = p;
    for (int d = 1; d <= int'(WIDTH); d = d * 2) begin
      gn = gp;
      pn = pp;
      for (int i = d; i <= int'(WIDTH); i++) begin
        gn[i] = gp[i] | (pp[i] & gp[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gp = gn;
      pp = pn;
    end
    c = {gp[WIDTH-1:0] | (pp[WIDTH-1:0] & {WIDTH{cin}}), cin};
    return p ^ c;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   part_q, part_d;   // signed partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, step_sum, corr_sum, rem_full;
  logic [WIDTH-1:0] quo_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  // Magnitude of the most-negative value is representable as unsigned.
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  always_comb begin
    shifted  = {part_q[WIDTH-1:0], quo_q[WIDTH-1]};
    // Sign of the previous partial remainder selects add or subtract. The shifted value may
    // wrap in WIDTH+1 bits, but the step result always lies in [-divisor, divisor).
    step_sum = part_q[WIDTH] ? cla_add(shifted, {1'b0, dvs_q}, 1'b0)
                             : cla_add(shifted, ~{1'b0, dvs_q}, 1'b1);
    quo_step = {quo_q[WIDTH-2:0], ~step_sum[WIDTH]};
    corr_sum = cla_add(step_sum, {1'b0, dvs_q}, 1'b0);
    rem_full = step_sum[WIDTH] ? corr_sum : step_sum;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    part_d      = part_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = StDone;
          end else begin
            part_d    = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        part_d = step_sum;
        quo_d  = quo_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          part_d      = rem_full;
          quotient_d  = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
          remainder_d = neg_rem_q ? (~rem_full[WIDTH-1:0] + 1'b1) : rem_full[WIDTH-1:0];
          dbz_d       = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      part_q      <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign busy        = (state_q == StCalc);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed cases with literal expectations
// plus randomized traffic checked every cycle against a transaction-level reference model.
module tb_seq_divider;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          signed_op;
  logic          in_valid, in_ready;
  logic [W-1:0]  dividend, divisor;
  logic          out_valid, out_ready;
  logic [W-1:0]  quotient, remainder;
  logic          div_by_zero, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Arithmetic reference straight from the division rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    int sa, sb;
    z = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0;
    end else begin
      sa = int'(a); sb = int'(b);
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
  endfunction

  // Model: phase 0 idle, 1 computing, 2 result offered.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_z, p_z, s_eff;

  always @(posedge clk) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    s_eff = signed_op;
`else
    s_eff = 1'b0;
`endif
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          ref_div(dividend, divisor, s_eff, p_q, p_r, p_z);
          if (divisor == 0) begin
            m_q = p_q; m_r = p_r; m_z = p_z; m_phase = 2;
          end else begin
            m_left = W; m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_q = p_q; m_r = p_r; m_z = p_z; m_phase = 2;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
      chk("busy", {31'b0, busy}, {31'b0, m_phase == 1});
      if (m_phase == 2) begin
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_z});
      end
    end
  end

  // One division with literal expectations; lat counts edges after the accept edge
  // (divide-by-zero results appear on the accept edge itself, so lat is 0 there).
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int hold, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ez, input int elat);
    int guard, lat;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    dividend = a; divisor = b; signed_op = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, {31'b0, div_by_zero}, {31'b0, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_q"}, quotient, eq);
      chk({tag, "_hold_r"}, remainder, er);
      chk({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1;

    do_div("basic", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, 32);
    do_div("dbz", 32'h1234_5678, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    do_div("bp", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 10, 32'hFFFF, 32'hFFFF, 1'b0, 32);
    do_div("lt", 32'd5, 32'd9, 1'b0, 0, 32'd0, 32'd5, 1'b0, 32);
    do_div("one", 32'hDEAD_BEEF, 32'd1, 1'b0, 0, 32'hDEAD_BEEF, 32'd0, 1'b0, 32);
    do_div("zero", 32'd0, 32'd13, 1'b0, 0, 32'd0, 32'd0, 1'b0, 32);

    // Abort mid-iteration.
    dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    do_div("after_rst", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0, 32);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0, 32);
    do_div("s_dbz", 32'hFFFF_FFF0, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 0);
`endif

    // Randomized traffic with random backpressure, ignored requests and rare resets.
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      signed_op = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0: dividend = '0;
        1: dividend = 32'h8000_0000;
        2: dividend = $urandom_range(0, 300);
        default: dividend = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: divisor = '0;
        1: divisor = 32'd1;
        2: divisor = 32'hFFFF_FFFF;
        3: divisor = $urandom_range(1, 255);
        default: divisor = $urandom;
      endcase
      rst_n = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
